// File: rtl/wdt_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg
// Shared definitions for the watchdog sequencer: FSM state encodings,
// register-file addresses and the default kick keys.
// -----------------------------------------------------------------------------
package wdt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_KEY1_SEEN = 2'd2,
      ST_RESETTING = 2'd3
   } wdt_state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_KICK   = 2'd2;
   localparam logic [1:0] ADDR_WARN   = 2'd3;

   localparam logic [15:0] KEY1_DEFAULT = 16'h600d;
   localparam logic [15:0] KEY2_DEFAULT = 16'hc0de;

endpackage

// File: rtl/wdt_down_counter.sv
// -----------------------------------------------------------------------------
// wdt_down_counter
// Loadable down-counter that saturates at zero.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val (wins over en)
//   load_val : value to load
//   en       : decrement by one, holding at zero
//   count    : current value
//   zero     : count == 0
// -----------------------------------------------------------------------------
module wdt_down_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/wdt_sequencer.sv
// -----------------------------------------------------------------------------
// wdt_sequencer
// Windowed watchdog with a two-key kick sequence, an early-warning pulse and
// a fixed-width system reset request.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   wr_valid  : one-cycle register write strobe
//   wr_addr   : 0=CTRL, 1=PERIOD, 2=KICK, 3=WARN
//   wr_data   : write data
//   wdt_reset : registered reset-request pulse, RESET_CYCLES wide
//   warn_irq  : one-cycle early-warning pulse
//   state     : current FSM state
//   count     : current countdown value
// -----------------------------------------------------------------------------
module wdt_sequencer
   import wdt_pkg::*;
#(
   parameter int unsigned PERIOD_W     = 32,
   parameter int unsigned RESET_CYCLES = 16,
   parameter logic [15:0] KEY1         = KEY1_DEFAULT,
   parameter logic [15:0] KEY2         = KEY2_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   input  logic [1:0]          wr_addr,
   input  logic [PERIOD_W-1:0] wr_data,
   output logic                wdt_reset,
   output logic                warn_irq,
   output logic [1:0]          state,
   output logic [PERIOD_W-1:0] count
);

   wdt_state_e          state_q, state_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] warn_q, warn_d;
   logic                wdt_reset_q, wdt_reset_d;
   logic                warn_irq_q, warn_irq_d;

   logic                cnt_load;
   logic [PERIOD_W-1:0] cnt_load_val;
   logic                cnt_en;
   logic [PERIOD_W-1:0] cnt;
   logic                cnt_zero;

   logic                counting;
   logic                kick;
   logic                key1_hit;
   logic                key2_hit;

   // One counter serves both phases: it counts the period while armed and
   // the remaining pulse width (RESET_CYCLES-1 down to 0) while resetting.
   wdt_down_counter #(
      .W (PERIOD_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   assign counting = (state_q == ST_ARMED) || (state_q == ST_KEY1_SEEN);
   assign kick     = wr_valid && (wr_addr == ADDR_KICK);
   assign key1_hit = kick && (wr_data[15:0] == KEY1);
   assign key2_hit = kick && (wr_data[15:0] == KEY2);
   assign cnt_en   = (state_q != ST_IDLE);

   always_comb begin
      state_d      = state_q;
      period_d     = period_q;
      warn_d       = warn_q;
      cnt_load     = 1'b0;
      cnt_load_val = period_q;

      unique case (state_q)
         ST_IDLE: begin
            if (wr_valid) begin
               unique case (wr_addr)
                  ADDR_CTRL: begin
                     if (wr_data[0]) begin
                        state_d  = ST_ARMED;
                        cnt_load = 1'b1;
                     end
                  end
                  ADDR_PERIOD: period_d = (wr_data == '0) ? PERIOD_W'(1) : wr_data;
                  ADDR_WARN:   warn_d   = wr_data;
                  default:     ;
               endcase
            end
         end
         ST_ARMED: begin
            // Expiry is checked first so a same-cycle kick cannot rescue it.
            if (cnt_zero) begin
               state_d      = ST_RESETTING;
               cnt_load     = 1'b1;
               cnt_load_val = PERIOD_W'(RESET_CYCLES - 1);
            end else if (key1_hit) begin
               state_d = ST_KEY1_SEEN;
            end
         end
         ST_KEY1_SEEN: begin
            if (cnt_zero) begin
               state_d      = ST_RESETTING;
               cnt_load     = 1'b1;
               cnt_load_val = PERIOD_W'(RESET_CYCLES - 1);
            end else if (key2_hit) begin
               state_d  = ST_ARMED;
               cnt_load = 1'b1;
            end else if (kick) begin
               state_d = ST_ARMED;
            end
         end
         ST_RESETTING: begin
            if (cnt_zero) begin
               state_d  = ST_ARMED;
               cnt_load = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The count only rests on WARN for one cycle while counting, since the
      // reload value (PERIOD) is excluded by WARN < PERIOD.
      warn_irq_d  = counting && (cnt == warn_q) && (warn_q != '0) && (warn_q < period_q);
      wdt_reset_d = (state_d == ST_RESETTING);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         period_q    <= '0;
         warn_q      <= '0;
         wdt_reset_q <= 1'b0;
         warn_irq_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         warn_q      <= warn_d;
         wdt_reset_q <= wdt_reset_d;
         warn_irq_q  <= warn_irq_d;
      end
   end

   assign wdt_reset = wdt_reset_q;
   assign warn_irq  = warn_irq_q;
   assign state     = state_q;
   assign count     = cnt;

endmodule

// File: tb/tb_wdt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wdt_sequencer
// Directed bench for wdt_sequencer with a cycle-level reference model that is
// compared against the DUT outputs on every falling edge after reset.
// -----------------------------------------------------------------------------
module tb_wdt_sequencer;

   localparam int          RC = 16;
   localparam logic [15:0] K1 = 16'h600d;
   localparam logic [15:0] K2 = 16'hc0de;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic [1:0]  wr_addr = 2'd0;
   logic [31:0] wr_data = '0;
   logic        wdt_reset;
   logic        warn_irq;
   logic [1:0]  state;
   logic [31:0] count;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   wdt_sequencer #(
      .PERIOD_W     (32),
      .RESET_CYCLES (RC),
      .KEY1         (K1),
      .KEY2         (K2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wdt_reset (wdt_reset),
      .warn_irq  (warn_irq),
      .state     (state),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: state as a number, count as a plain integer.
   int     m_st   = 0;
   longint m_cnt  = 0;
   longint m_per  = 0;
   longint m_warn = 0;
   bit     m_wdt  = 1'b0;
   bit     m_irq  = 1'b0;

   always @(posedge clk) begin
      bit          irq_n;
      bit          kck;
      logic [15:0] key;
      irq_n = (m_st == 1 || m_st == 2) && m_cnt == m_warn && m_warn != 0 && m_warn < m_per;
      kck   = wr_valid && wr_addr == 2'd2;
      key   = wr_data[15:0];
      if (rst) begin
         m_st = 0; m_cnt = 0; m_per = 0; m_warn = 0; irq_n = 1'b0;
      end else begin
         case (m_st)
            0: if (wr_valid) begin
                  if (wr_addr == 2'd0 && wr_data[0]) begin m_st = 1; m_cnt = m_per; end
                  else if (wr_addr == 2'd1) m_per = (wr_data == 0) ? 1 : longint'(wr_data);
                  else if (wr_addr == 2'd3) m_warn = longint'(wr_data);
               end
            1, 2: if (m_cnt == 0) begin
                  m_st = 3; m_cnt = RC - 1;
               end else begin
                  m_cnt = m_cnt - 1;
                  if (m_st == 1 && kck && key == K1) m_st = 2;
                  else if (m_st == 2 && kck) begin
                     m_st = 1;
                     if (key == K2) m_cnt = m_per;
                  end
               end
            default: if (m_cnt == 0) begin m_st = 1; m_cnt = m_per; end
                     else m_cnt = m_cnt - 1;
         endcase
      end
      m_irq = irq_n;
      m_wdt = (m_st == 3);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_state", state, m_st);
         check("model_count", count, m_cnt);
         check("model_wdt_reset", wdt_reset, m_wdt);
         check("model_warn_irq", warn_irq, m_irq);
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_valid = 1'b0; wr_data = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_wdt(output int k);
      k = 0;
      while (!wdt_reset && k < 300) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic high_len(output int h);
      h = 0;
      while (wdt_reset && h < 100) begin
         h++;
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k, h, np, pk;
      bit seen;
      int warn_v [3] = '{10, 0, 50};
      int exp_np [3] = '{1, 0, 0};
      int exp_pk [3] = '{41, 0, 0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_state", state, 0);
      check("reset_count", count, 0);
      check("reset_wdt", wdt_reset, 0);
      check("reset_warn", warn_irq, 0);

      // Free-running expiry with PERIOD=100
      wr(2'd1, 100);
      wr(2'd0, 1);
      check("enable_state", state, 1);
      check("enable_count", count, 100);
      check("model_pin_count", m_cnt, 100);
      wait_wdt(k);
      check("expiry_latency", k, 101);
      high_len(h);
      check("pulse_width", h, 16);
      check("post_pulse_state", state, 1);
      check("post_pulse_count", count, 100);

      // Valid two-key kick at count 40
      do_rst();
      wr(2'd1, 100);
      wr(2'd0, 1);
      idle(59);
      check("pre_kick_count", count, 41);
      wr(2'd2, {16'h0, K1});
      check("key1_state", state, 2);
      wr(2'd2, {16'h0, K2});
      check("kick_reload_count", count, 100);
      check("kick_reload_state", state, 1);
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (wdt_reset) seen = 1'b1;
      end
      check("no_reset_after_kick", seen, 0);

      // Broken sequence: KEY1, wrong key, KEY2
      do_rst();
      wr(2'd1, 100);
      wr(2'd0, 1);
      idle(10);
      wr(2'd2, {16'h0, K1});
      wr(2'd2, 32'h0000_1234);
      check("bad_key_state", state, 1);
      wr(2'd2, {16'h0, K2});
      check("key2_armed_state", state, 1);
      check("no_reload_count", count, 87);
      wait_wdt(k);
      check("unchanged_expiry", k, 88);

      // Early warning: valid, zero, and WARN >= PERIOD
      for (int i = 0; i < 3; i++) begin
         do_rst();
         wr(2'd1, 50);
         wr(2'd3, warn_v[i]);
         wr(2'd0, 1);
         np = 0; pk = 0;
         for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (warn_irq) begin
               np++;
               if (pk == 0) pk = c;
            end
         end
         check($sformatf("warn_pulses_%0d", warn_v[i]), np, exp_np[i]);
         check($sformatf("warn_cycle_%0d", warn_v[i]), pk, exp_pk[i]);
      end

      // Ignored writes after enable; KEY2 coincident with expiry
      do_rst();
      wr(2'd1, 5);
      wr(2'd0, 1);
      wr(2'd0, 0);
      check("ctrl0_ignored_state", state, 1);
      check("ctrl0_count", count, 4);
      wr(2'd1, 9);
      wr(2'd2, {16'h0, K1});
      check("k1_state", state, 2);
      idle(2);
      check("at_zero_count", count, 0);
      wr(2'd2, {16'h0, K2});
      check("expiry_beats_kick_state", state, 3);
      check("expiry_beats_kick_wdt", wdt_reset, 1);
      wr(2'd1, 7);
      high_len(h);
      check("pulse_rest_width", h, 15);
      check("period_write_ignored", count, 5);

      // PERIOD 0 loads as 1; kicks in IDLE ignored
      do_rst();
      wr(2'd1, 0);
      wr(2'd2, {16'h0, K1});
      check("idle_kick_state", state, 0);
      wr(2'd0, 1);
      check("period0_count", count, 1);
      wait_wdt(k);
      check("period0_expiry", k, 2);

      // rst during the 5th RESETTING cycle
      do_rst();
      wr(2'd1, 3);
      wr(2'd0, 1);
      wait_wdt(k);
      check("short_expiry", k, 4);
      idle(4);
      check("fifth_cycle_wdt", wdt_reset, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_wdt", wdt_reset, 0);
      check("abort_state", state, 0);
      check("abort_count", count, 0);
      wr(2'd1, 4);
      wr(2'd0, 1);
      check("reenable_state", state, 1);
      check("reenable_count", count, 4);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wdt_sequencer.md
WDT_SEQUENCER -- requirements
Module: wdt_sequencer

Interface
REQ-001 Parameter PERIOD_W, default 32, width of period/counter registers.
REQ-002 Parameter RESET_CYCLES, default 16, width of wdt_reset pulse in clk cycles.
REQ-003 Parameter KEY1, default 16'h600d, first kick key; KEY2, default 16'hc0de, second kick key.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_valid  in  1  one-cycle register write strobe.
REQ-007 wr_addr  in  2  0=CTRL, 1=PERIOD, 2=KICK, 3=WARN.
REQ-008 wr_data  in  PERIOD_W  write data.
REQ-009 wdt_reset  out  1  system reset request pulse.
REQ-010 warn_irq  out  1  one-cycle early-warning pulse.
REQ-011 state  out  2  current FSM state encoding.
REQ-012 count  out  PERIOD_W  current countdown value.

Function
REQ-013 States: IDLE(0), ARMED(1), KEY1_SEEN(2), RESETTING(3).
REQ-014 CTRL bit0 write of 1 in IDLE: next cycle state=ARMED, count=PERIOD reg; enable is write-once -- writes of 0 or 1 outside IDLE are ignored.
REQ-015 PERIOD and WARN writes accepted only in IDLE; ignored otherwise; PERIOD value 0 is loaded as 1.
REQ-016 In ARMED and KEY1_SEEN, count decrements by 1 per cycle, no wrap below 0.
REQ-017 KICK write with wr_data[15:0]==KEY1 in ARMED -> KEY1_SEEN next cycle; no reload.
REQ-018 KICK write with KEY2 in KEY1_SEEN -> ARMED, count=PERIOD next cycle.
REQ-019 Any other KICK write in KEY1_SEEN -> ARMED, no reload; KEY2 in ARMED ignored; KICK writes in IDLE ignored.
REQ-020 warn_irq pulses high exactly one cycle on the cycle after count transitions to WARN reg value; never if WARN==0 or WARN>=PERIOD.
REQ-021 count==0 in ARMED or KEY1_SEEN -> RESETTING next cycle; expiry takes precedence over a simultaneous KICK write.
REQ-022 In RESETTING wdt_reset=1 for exactly RESET_CYCLES consecutive cycles, then state=ARMED with count=PERIOD; all writes ignored while RESETTING.
REQ-023 wdt_reset is registered, glitch-free, and low in all states except RESETTING.
REQ-024 Latency: every write takes effect on the cycle after wr_valid is sampled.

Reset
REQ-025 rst sampled high: state=IDLE, count=0, PERIOD reg=0, WARN reg=0, wdt_reset=0, warn_irq=0, pulse counter=0, next cycle.
REQ-026 rst high mid-RESETTING terminates the pulse immediately (wdt_reset=0 next cycle); the enable lock is cleared only by rst.

Structure
REQ-027 State encodings, register addresses and key defaults reside in a shared package wdt_pkg.
REQ-028 Single module with one internal countdown sub-module wdt_down_counter (load, enable, zero flag) reused for period and pulse-width counting.

Verification
REQ-029 PERIOD=100, enable -> count=100 next cycle, wdt_reset rises 101 cycles later, high 16 cycles, then state=ARMED count=100.
REQ-030 PERIOD=100, KEY1 then KEY2 at count=40 -> count=100 one cycle after KEY2 write, no wdt_reset within first 140 cycles.
REQ-031 KEY1 then 16'h1234 then KEY2 -> state returns ARMED, count not reloaded, expiry unchanged.
REQ-032 PERIOD=50, WARN=10 -> warn_irq single pulse cycle after count==10; WARN=0 -> no pulse.
REQ-033 KEY2 write coincident with count==0 -> RESETTING; CTRL write 0 and PERIOD write after enable -> ignored.
REQ-034 rst asserted on 5th cycle of RESETTING -> wdt_reset=0, state=IDLE next cycle; enable re-accepted.
